wght_mc_rcv: RTL

// - Receive side of the weight multicast path. The weight load controller issues GLB reads

---
 rtl/wght_mc_rcv_if.sv | 37 +++
 rtl/wght_mc_rcv.sv | 132 +++++++++++++
 2 files changed

// File: rtl/wght_mc_rcv_if.sv
// Handshake bundle for the weight multicast receiver.
// Carries pass control (start, IDs, expected count), the tagged GLB word stream,
// the PE-side valid/ready output, and the status outputs.
// Modports:
//   master - upstream/controller view (drives i_*, observes o_*)
//   slave  - receiver view (observes i_*, drives o_*)
interface wght_mc_rcv_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned CNT_W  = 10
);
  logic              i_start;
  logic [3:0]        i_cfg_row_id;
  logic [3:0]        i_cfg_col_id;
  logic [CNT_W-1:0]  i_cfg_expect;
  logic              i_wght_valid;
  logic [7:0]        i_wght_tag;
  logic [DATA_W-1:0] i_wght_data;
  logic              o_pe_valid;
  logic [DATA_W-1:0] o_pe_data;
  logic              i_pe_ready;
  logic              o_busy;
  logic              o_rcv_done;
  logic              o_overflow;
  logic [CNT_W-1:0]  o_acc_cnt;

  modport master (
    output i_start, i_cfg_row_id, i_cfg_col_id, i_cfg_expect,
    output i_wght_valid, i_wght_tag, i_wght_data, i_pe_ready,
    input  o_pe_valid, o_pe_data, o_busy, o_rcv_done, o_overflow, o_acc_cnt
  );

  modport slave (
    input  i_start, i_cfg_row_id, i_cfg_col_id, i_cfg_expect,
    input  i_wght_valid, i_wght_tag, i_wght_data, i_pe_ready,
    output o_pe_valid, o_pe_data, o_busy, o_rcv_done, o_overflow, o_acc_cnt
  );
endinterface

// File: rtl/wght_mc_rcv.sv
// Weight multicast receive endpoint.
// Filters the tagged GLB weight stream against this endpoint's {row, col} ID, buffers
// matching words in a small first-word-fall-through FIFO and hands them to the PE
// scratchpad over valid/ready. Counts accepted words against the per-pass expected
// count and pulses o_rcv_done once the pass is complete and the buffer has drained.
// Ports:
//   i_clk, i_rst - clock, asynchronous active-high reset
//   bus (slave)  - control, tagged word input, PE output and status (see wght_mc_rcv_if)
// Build option:
//   WGHT_MC_BCAST_EN - when defined, col_tag 4'hF matches any configured column ID
//                      (row broadcast); row_tag is still compared exactly.
module wght_mc_rcv #(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned CNT_W      = 10
) (
  input logic          i_clk,
  input logic          i_rst,
  wght_mc_rcv_if.slave bus
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned OccW = PtrW + 1;
  localparam logic [OccW-1:0] OccFull = OccW'(FIFO_DEPTH);

  typedef enum logic [1:0] {StIdle, StRecv, StDrain, StDone} state_e;

  state_e            state_q;
  logic [CNT_W-1:0]  expect_q;
  logic [CNT_W-1:0]  acc_cnt_q;
  logic              overflow_q;
  logic              busy_q;
  logic              done_q;

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]   wr_ptr_q;
  logic [PtrW-1:0]   rd_ptr_q;
  logic [OccW-1:0]   occ_q;

  logic row_hit, col_hit, tag_match;
  logic accept, push, pop, drop, full, empty;

  // Tag field 0 is reserved and never matches.
  always_comb begin
    row_hit = (bus.i_wght_tag[7:4] != 4'h0) && (bus.i_wght_tag[7:4] == bus.i_cfg_row_id);
`ifdef WGHT_MC_BCAST_EN
    col_hit = (bus.i_wght_tag[3:0] != 4'h0) &&
              ((bus.i_wght_tag[3:0] == bus.i_cfg_col_id) || (bus.i_wght_tag[3:0] == 4'hF));
`else
    col_hit = (bus.i_wght_tag[3:0] != 4'h0) && (bus.i_wght_tag[3:0] == bus.i_cfg_col_id);
`endif
    tag_match = row_hit && col_hit;
  end

  assign empty = (occ_q == '0);
  assign full  = (occ_q == OccFull);
  assign pop   = !empty && bus.i_pe_ready;
  // Once the expected count is reached the pass is closing; later words are not counted.
  assign accept = (state_q == StRecv) && bus.i_wght_valid && tag_match &&
                  (acc_cnt_q != expect_q);
  // A pop in the same cycle frees the slot, so a full buffer can still take the word.
  assign push  = accept && (!full || pop);
  assign drop  = accept && full && !pop;

  // Match buffer.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= bus.i_wght_data;
        wr_ptr_q        <= wr_ptr_q + PtrW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PtrW'(1);
      if (push && !pop)      occ_q <= occ_q + OccW'(1);
      else if (!push && pop) occ_q <= occ_q - OccW'(1);
    end
  end

  // Pass control FSM with registered status outputs.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= StIdle;
      expect_q   <= '0;
      acc_cnt_q  <= '0;
      overflow_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          done_q <= 1'b0;
          if (bus.i_start) begin
            state_q    <= StRecv;
            expect_q   <= bus.i_cfg_expect;
            acc_cnt_q  <= '0;
            overflow_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        StRecv: begin
          if (accept && (acc_cnt_q != '1)) acc_cnt_q <= acc_cnt_q + CNT_W'(1);
          if (drop) overflow_q <= 1'b1;
          if (acc_cnt_q == expect_q) state_q <= StDrain;
        end
        StDrain: begin
          if (empty) begin
            state_q <= StDone;
            done_q  <= 1'b1;
          end
        end
        StDone: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.o_pe_valid = !empty;
  assign bus.o_pe_data  = mem_q[rd_ptr_q];
  assign bus.o_busy     = busy_q;
  assign bus.o_rcv_done = done_q;
  assign bus.o_overflow = overflow_q;
  assign bus.o_acc_cnt  = acc_cnt_q;

endmodule
